// File: rtl/nibble_demux_collector.sv
// Nibble demultiplexer/collector: steers a valid/ready stream of 4-bit nibbles
// into the slots of a wide assembly register and presents each completed word
// on its own valid/ready handshake.
module nibble_demux_collector #(
  parameter int unsigned NIBBLES   = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3:0]           in_nibble_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NIBBLES-1:0] out_word_o,
  output logic [4:0]           out_count_o
);

  localparam int unsigned W = 4 * NIBBLES;

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [W-1:0]   asm_q, asm_d;
  logic [W-1:0]   word_q, word_d;
  logic [4:0]     count_q, count_d;

  logic           accept;
  logic           xfer;
  logic           done;
  logic [3:0]     slot;
  logic [W-1:0]   merged;

  // Handshakes, slot addressing and the assembly word with the new nibble merged in.
  always_comb begin
    in_ready_o  = (state_q == StFill) | out_ready_i;
    out_valid_o = (state_q == StFull);
    out_word_o  = word_q;
    out_count_o = count_q;

    accept = in_valid_i & in_ready_o;
    xfer   = (state_q == StFull) & out_ready_i;
    done   = accept & (in_last_i | (idx_q == 4'(NIBBLES - 1)));

    slot   = LSB_FIRST ? idx_q : (4'(NIBBLES - 1) - idx_q);
    merged = asm_q;
    // Slots beyond idx are already zero: the register is cleared on every completion.
    merged[{slot, 2'b00} +: 4] = in_nibble_i;
  end

  // Next-state: write the addressed slot, close the word on last/full, release on transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    word_d  = word_q;
    count_d = count_q;

    if (done) begin
      word_d  = merged;
      count_d = {1'b0, idx_q} + 5'd1;
      asm_d   = '0;
      idx_d   = '0;
      state_d = StFull;
    end else begin
      if (accept) begin
        asm_d = merged;
        idx_d = idx_q + 4'd1;
      end
      // A transfer without a closing nibble returns to filling; an accept in the
      // same cycle has already landed in slot 0 of the cleared register above.
      if (xfer) begin
        state_d = StFill;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFill;
      idx_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_nibble_demux_collector.sv
// Directed bench for nibble_demux_collector: one LSB-first and one MSB-first
// instance share all inputs; a queue scoreboard checks every word transfer and
// directed checks cover reset, backpressure, spacing and single-nibble words.
module tb_nibble_demux_collector;

  typedef struct packed {
    logic [63:0] word;
    logic [4:0]  count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_nibble = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [63:0] out_word1, out_word0;
  logic [4:0]  out_count1, out_count0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_xfer = 0;
  int last_xfer = 0;
  int prev_xfer = 0;
  int stalls = 0;

  exp_t q1[$];
  exp_t q0[$];

  // Reference model state for both slot orientations
  int          m_idx = 0;
  logic [63:0] m_asm1 = '0;
  logic [63:0] m_asm0 = '0;

  nibble_demux_collector #(.NIBBLES(16), .LSB_FIRST(1'b1)) u_dut1 (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready1),
    .in_nibble_i (in_nibble),
    .in_last_i   (in_last),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready),
    .out_word_o  (out_word1),
    .out_count_o (out_count1)
  );

  nibble_demux_collector #(.NIBBLES(16), .LSB_FIRST(1'b0)) u_dut0 (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready0),
    .in_nibble_i (in_nibble),
    .in_last_i   (in_last),
    .out_valid_o (out_valid0),
    .out_ready_i (out_ready),
    .out_word_o  (out_word0),
    .out_count_o (out_count0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    m_idx  = 0;
    m_asm1 = '0;
    m_asm0 = '0;
  endtask

  // Drive one nibble (from posedge+1) and wait, bounded, until it is accepted.
  task automatic send(input logic [3:0] n, input logic last);
    int budget;
    exp_t e;
    in_valid  = 1'b1;
    in_nibble = n;
    in_last   = last;
    budget    = 50;
    #1;
    while (!in_ready1 && budget > 0) begin
      stalls++;
      budget--;
      @(posedge clk);
      #2;
    end
    if (budget == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL accept_timeout: observed in_ready=0 for 50 cycles expected accept");
    end else begin
      m_asm1[4*m_idx +: 4]      = n;
      m_asm0[60 - 4*m_idx +: 4] = n;
      if (last || m_idx == 15) begin
        e.count = 5'(m_idx + 1);
        e.word  = m_asm1;
        q1.push_back(e);
        e.word  = m_asm0;
        q0.push_back(e);
        model_clear();
      end else begin
        m_idx++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop and compare on every output transfer of each instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL sb1_unexpected: observed word %h expected no transfer", out_word1);
        end else begin
          e = q1.pop_front();
          check("sb1_word", out_word1, e.word);
          check("sb1_count", 64'(out_count1), 64'(e.count));
        end
        prev_xfer = last_xfer;
        last_xfer = cyc;
        n_xfer++;
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL sb0_unexpected: observed word %h expected no transfer", out_word0);
        end else begin
          e = q0.pop_front();
          check("sb0_word", out_word0, e.word);
          check("sb0_count", 64'(out_count0), 64'(e.count));
        end
      end
    end
  end

  initial begin
    int x0;
    // Reset state
    step(2);
    reset = 1'b0;
    check("rst_valid", 64'(out_valid1), 64'd0);
    check("rst_word", out_word1, 64'd0);
    check("rst_count", 64'(out_count1), 64'd0);
    check("rst_ready", 64'(in_ready1), 64'd1);

    // Full 16-nibble word, LSB first, consumer always ready
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 16; i++) send(4'(i + 1), 1'b0);
    in_valid = 1'b0;
    check("full_stalls", 64'(stalls), 64'd0);
    check("full_valid", 64'(out_valid1), 64'd1);
    check("full_word", out_word1, 64'h0FED_CBA9_8765_4321);
    check("full_count", 64'(out_count1), 64'd16);
    step(1);

    // Early close, both orientations
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b1);
    in_valid = 1'b0;
    check("early_word_lsb", out_word1, 64'h0000_0000_0000_0CBA);
    check("early_word_msb", out_word0, 64'hABC0_0000_0000_0000);
    check("early_count", 64'(out_count1), 64'd3);
    step(1);

    // Backpressure: word held while the consumer stalls, pending nibble waits
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'(15 - i), 1'b0);
    in_valid  = 1'b1;
    in_nibble = 4'h7;
    in_last   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 64'(in_ready1), 64'd0);
      check("bp_word", out_word1, 64'h0123_4567_89AB_CDEF);
      step(1);
    end
    out_ready = 1'b1;
    send(4'h7, 1'b0);
    check("bp_after_valid", 64'(out_valid1), 64'd0);
    send(4'h8, 1'b1);
    in_valid = 1'b0;
    check("bp_slot0_word", out_word1, 64'h87);
    check("bp_slot0_count", 64'(out_count1), 64'd2);
    step(2);

    // Back-to-back words with no idle input cycles
    stalls = 0;
    x0 = n_xfer;
    for (int i = 0; i < 32; i++) send(4'(i) ^ 4'h5, 1'b0);
    in_valid = 1'b0;
    step(2);
    check("b2b_stalls", 64'(stalls), 64'd0);
    check("b2b_xfers", 64'(n_xfer - x0), 64'd2);
    check("b2b_spacing", 64'(last_xfer - prev_xfer), 64'd16);

    // Reset mid-word discards the partial word
    for (int i = 0; i < 9; i++) send(4'hF, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    model_clear();
    check("midrst_valid", 64'(out_valid1), 64'd0);
    check("midrst_word", out_word1, 64'd0);
    check("midrst_count", 64'(out_count1), 64'd0);
    for (int i = 0; i < 16; i++) send(4'(i), 1'b0);
    in_valid = 1'b0;
    check("midrst_new_word", out_word1, 64'hFEDC_BA98_7654_3210);
    check("midrst_new_msb", out_word0, 64'h0123_4567_89AB_CDEF);
    step(1);

    // Single-nibble words straight through the FULL state
    send(4'h3, 1'b1);
    check("single1_word", out_word1, 64'h3);
    check("single1_count", 64'(out_count1), 64'd1);
    check("single1_valid", 64'(out_valid1), 64'd1);
    send(4'h5, 1'b1);
    in_valid = 1'b0;
    check("single2_word", out_word1, 64'h5);
    check("single2_count", 64'(out_count1), 64'd1);
    check("single2_valid", 64'(out_valid1), 64'd1);
    step(3);

    check("sb1_drained", 64'(q1.size()), 64'd0);
    check("sb0_drained", 64'(q0.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_demux_collector.md
Name: nibble_demux_collector

Overview:
- Write-side counterpart to the multiplier's 16-way, 4-bit nibble selector.
- Accepts a serial stream of 4-bit nibbles over a valid/ready handshake and steers each one into slot 0..15 of a 64-bit assembly register.
- Presents the completed word with its own valid/ready handshake.
- Used to rebuild 64-bit products/operands from radix-16 digit streams in the Mips multiplier path.

Parameters:
- NIBBLES, 16, number of 4-bit slots per word; the output word is 4*NIBBLES bits. Only 16 is supported.
- LSB_FIRST, 1, 1: the first nibble goes to bits [3:0]. 0: the first nibble goes to bits [63:60].

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_nibble is valid this cycle.
- in_ready  output  1  block can accept a nibble this cycle.
- in_nibble  input  4  nibble data.
- in_last  input  1  with an accepted nibble: close the word early, zero-padding the unfilled slots.
- out_valid  output  1  out_word is complete and stable.
- out_ready  input  1  consumer takes out_word this cycle.
- out_word  output  64  assembled word.
- out_count  output  5  number of nibbles actually written into out_word (1..16); valid while out_valid.

Behaviour:
- Reset (synchronous, active-high, on clk edge):
  - state=FILL, slot index idx=0, assembly register=0.
  - out_valid=0, out_word=0, out_count=0, in_ready=1.
  - Reset overrides any simultaneous handshake. Reset mid-word discards the partial word.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Inputs are sampled only on accept.
  - Once out_valid=1, out_word and out_count hold stable until transfer.
- Slot mapping:
  - LSB_FIRST=1: accepted nibble k goes to bits [4k+3:4k].
  - LSB_FIRST=0: accepted nibble k goes to bits [63-4k:60-4k].
  - Only the addressed slot changes; the other slots hold.
- State FILL:
  - in_ready=1, out_valid=0.
  - On accept with idx<15 and in_last=0: write the slot, idx<=idx+1.
  - On accept with idx==15, or with in_last=1: write the slot, then:
    - out_word <= the assembled word with the new nibble included; slots above idx are forced to 0.
    - out_count <= idx+1.
    - out_valid<=1, idx<=0, assembly register<=0, state<=FULL.
  - No accept: hold.
- State FULL:
  - out_valid=1, in_ready=out_ready (back-to-back pass-through).
  - Transfer without accept: out_valid<=0, state<=FILL.
  - Transfer with accept in the same cycle: the new nibble is written to slot 0 of the cleared register and idx<=1, with the FILL rules applied.
    - If the new nibble has in_last=1, out_word reloads immediately with that single nibble, out_count=1, out_valid stays 1, state stays FULL.
  - No transfer: in_ready=0 and the nibble is not accepted (no drop, no overwrite).
- Latency:
  - The word is visible on out_word/out_valid on the cycle after the final nibble is accepted.
  - Sustained throughput is 1 nibble/clk with no bubble between words, provided out_ready is held high.
- Widths:
  - idx is 4 bits and wraps 15->0 only through the completion path.
  - out_count is 5 bits so that it can represent 16.
- Not supported: an empty word (in_last without a nibble).

Test Plan:
- Full word, LSB_FIRST=1, out_ready=1: nibbles 0x1,0x2,...,0xF,0x0 on 16 consecutive cycles -> one cycle after the 16th accept, out_valid=1, out_word=0x0FEDCBA987654321, out_count=16; in_ready stays 1 throughout.
- Early close: nibbles 0xA,0xB,0xC, with in_last on 0xC -> out_word=0x0000000000000CBA, out_count=3. With LSB_FIRST=0, the same stimulus -> out_word=0xABC0000000000000.
- Backpressure: complete a word with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_word stable for all 5 cycles; on out_ready=1 the word transfers and the pending nibble 0x7 lands in slot 0 in that same cycle.
- Back-to-back: two 16-nibble words streamed continuously with out_ready=1 -> two transfers exactly 16 cycles apart, with zero idle input cycles.
- Reset mid-word: after 9 accepted nibbles assert reset for 1 cycle -> next cycle out_valid=0, out_word=0, out_count=0; a following 16-nibble word assembles correctly with no residue from the discarded nibbles.
- Single-nibble words in FULL: hold out_ready=1 and feed in_valid=1 with in_last=1 every cycle, nibble values 0x3 then 0x5 -> out_word=0x3 with out_count=1, then out_word=0x5; out_valid stays high continuously.
